// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem reads and
// buffers up to two returned words in order for decode; redirects flush everything.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  logic [31:0] pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop;
  logic [1:0]  occupancy;
  logic [31:0] fifo_data [2];
  logic [31:0] fifo_pc   [2];
  logic        head;
  logic [31:0] inflight_addr [2];
  logic        inflight_wr;
  logic        inflight_rd;

  logic        req_fire;
  logic        resp_fire;
  logic        deq;
  logic        enq;
  logic        wr_idx;
  logic [2:0]  credit_used;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Outstanding requests and queued words share two credits, so the FIFO can never overflow.
  assign credit_used    = {1'b0, outstanding} + {1'b0, occupancy};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < 3'd2);
  assign imem_req_addr  = pc;

  assign req_fire  = imem_req_valid & imem_req_ready;
  assign resp_fire = imem_resp_valid;
  assign deq       = instr_valid & instr_ready & !redirect_valid;
  assign enq       = resp_fire & (drop == 2'd0) & !redirect_valid;
  assign wr_idx    = head ^ occupancy[0];

  assign instr_valid = (occupancy != 2'd0);
  assign instruction = fifo_data[head];
  assign instr_pc    = fifo_pc[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + {1'b0, req_fire} - {1'b0, resp_fire};
      // Everything still in flight at a redirect belongs to the old stream.
      if (redirect_valid) begin
        drop <= outstanding - {1'b0, resp_fire};
      end else if (resp_fire && (drop != 2'd0)) begin
        drop <= drop - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        inflight_addr[i] <= '0;
      end
      inflight_wr <= 1'b0;
      inflight_rd <= 1'b0;
    end else begin
      if (req_fire) begin
        inflight_addr[inflight_wr] <= pc;
        inflight_wr                <= ~inflight_wr;
      end
      if (resp_fire) begin
        inflight_rd <= ~inflight_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
      head      <= 1'b0;
      occupancy <= '0;
    end else begin
      if (enq) begin
        fifo_data[wr_idx] <= imem_resp_data;
        fifo_pc[wr_idx]   <= inflight_addr[inflight_rd];
      end
      if (deq) begin
        head <= ~head;
      end
      if (redirect_valid) begin
        occupancy <= '0;
      end else if (enq && !deq) begin
        occupancy <= occupancy + 2'd1;
      end else if (deq && !enq) begin
        occupancy <= occupancy - 2'd1;
      end
    end
  end

endmodule
